// File: rtl/pc_branch_ctrl.sv
// Fetch PC register with branch redirect, stall-deferred redirect and pipeline flush pulse.
// State | meaning: RUN = normal fetch | PENDING = taken branch waiting out a stall | FLUSH = redirect cycle, flush IF/ID and ID/EX
module pc_branch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        addermuxselect,
  input  logic [63:0] branch_target,
  output logic [63:0] pc_out,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        misalign_err,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc_q, pc_nxt;
  logic [63:0] pend_q, pend_nxt;
  logic        flush_q, flush_nxt;
  logic        misalign_q, misalign_nxt;
  logic [31:0] branch_cnt_q, taken_cnt_q;
  logic        branch_inc, taken_inc;
  logic        redirect_req;

  assign redirect_req = branch_valid & addermuxselect;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    pend_nxt     = pend_q;
    misalign_nxt = 1'b0;
    branch_inc   = 1'b0;
    taken_inc    = 1'b0;
    case (state)
      RUN: begin
        branch_inc = branch_valid;
        if (redirect_req) begin
          taken_inc = 1'b1;
          if (stall) begin
            pend_nxt  = branch_target;
            state_nxt = PENDING;
          end else begin
            pc_nxt       = {branch_target[63:2], 2'b00};
            misalign_nxt = |branch_target[1:0];
            state_nxt    = FLUSH;
          end
        end else if (!stall) begin
          pc_nxt = pc_q + PC_STEP;
        end
      end
      PENDING: begin
        // Branch inputs are ignored here so a second redirect cannot be issued.
        if (!stall) begin
          pc_nxt       = {pend_q[63:2], 2'b00};
          misalign_nxt = |pend_q[1:0];
          state_nxt    = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall) pc_nxt = pc_q + PC_STEP;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    flush_nxt = (state_nxt == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      pc_q         <= RESET_PC;
      pend_q       <= 64'h0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
      branch_cnt_q <= 32'h0;
      taken_cnt_q  <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      pend_q     <= pend_nxt;
      flush_q    <= flush_nxt;
      misalign_q <= misalign_nxt;
      if (branch_inc && (branch_cnt_q != 32'hFFFF_FFFF)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (taken_inc && (taken_cnt_q != 32'hFFFF_FFFF)) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign pc_out       = pc_q;
  assign if_id_flush  = flush_q;
  assign id_ex_flush  = flush_q;
  assign misalign_err = misalign_q;
  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pc_branch_ctrl;
  logic        clk = 1'b0;
  logic        reset, stall, branch_valid, addermuxselect;
  logic [63:0] branch_target;
  logic [63:0] pc_out;
  logic        if_id_flush, id_ex_flush, misalign_err;
  logic [31:0] branch_count, taken_count;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Behavioural model: a redirect is either waiting for the stall to clear or is being flushed now.
  logic [63:0] m_pc = 64'h0;
  bit          m_waiting = 1'b0;
  logic [63:0] m_wait_tgt = 64'h0;
  bit          m_flushing = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_bc = 32'h0, m_tc = 32'h0;

  pc_branch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .addermuxselect(addermuxselect), .branch_target(branch_target),
    .pc_out(pc_out), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .misalign_err(misalign_err), .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic void redirect_to(input logic [63:0] tgt);
    m_pc       = tgt & ~64'h3;
    m_flushing = 1'b1;
    m_mis      = (tgt % 4) != 0;
  endfunction

  function automatic void model_update();
    bit was_flushing;
    was_flushing = m_flushing;
    m_flushing = 1'b0;
    m_mis = 1'b0;
    if (!reset) begin
      m_pc = 64'h0; m_waiting = 1'b0; m_wait_tgt = 64'h0; m_bc = 32'h0; m_tc = 32'h0;
    end else if (was_flushing) begin
      if (!stall) m_pc = m_pc + 64'd4;
    end else if (m_waiting) begin
      if (!stall) begin
        m_waiting = 1'b0;
        redirect_to(m_wait_tgt);
      end
    end else begin
      if (branch_valid) m_bc = sat_inc(m_bc);
      if (branch_valid && addermuxselect) begin
        m_tc = sat_inc(m_tc);
        if (stall) begin
          m_waiting = 1'b1;
          m_wait_tgt = branch_target;
        end else begin
          redirect_to(branch_target);
        end
      end else if (!stall) begin
        m_pc = m_pc + 64'd4;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("pc_out", pc_out, m_pc);
      chk("if_id_flush", {63'h0, if_id_flush}, {63'h0, m_flushing});
      chk("id_ex_flush", {63'h0, id_ex_flush}, {63'h0, m_flushing});
      chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_mis});
      chk("branch_count", {32'h0, branch_count}, {32'h0, m_bc});
      chk("taken_count", {32'h0, taken_count}, {32'h0, m_tc});
    end
  end

  task automatic step(input logic r, input logic s, input logic bv, input logic am, input logic [63:0] bt);
    @(negedge clk);
    reset = r; stall = s; branch_valid = bv; addermuxselect = am; branch_target = bt;
    @(posedge clk);
    #1;
    model_update();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_valid = 1'b0; addermuxselect = 1'b0; branch_target = 64'h0;

    // Reset dominates every other input.
    step(0, 0, 0, 0, 64'h0);
    check_en = 1'b1;
    step(0, 1, 1, 1, 64'h55);
    chk("reset_pc", pc_out, 64'h0);
    chk("reset_flush", {63'h0, if_id_flush | id_ex_flush}, 64'h0);
    chk("reset_counts", {branch_count, taken_count}, 64'h0);

    // Sequential fetch 0,4,8,12 then 0x10.
    step(1, 0, 0, 0, 64'h0); chk("seq_4", pc_out, 64'h4);
    step(1, 0, 0, 0, 64'h0); chk("seq_8", pc_out, 64'h8);
    step(1, 0, 0, 0, 64'h0); chk("seq_12", pc_out, 64'hC);
    step(1, 0, 0, 0, 64'h0); chk("seq_16", pc_out, 64'h10);

    // Taken branch from 0x10 to 0x100.
    step(1, 0, 1, 1, 64'h100);
    chk("taken_pc", pc_out, 64'h100);
    chk("taken_flush", {62'h0, if_id_flush, id_ex_flush}, 64'h3);
    step(1, 0, 0, 0, 64'h0);
    chk("after_taken_pc", pc_out, 64'h104);
    chk("after_taken_flush", {62'h0, if_id_flush, id_ex_flush}, 64'h0);
    chk("taken_count_1", {32'h0, taken_count}, 64'h1);

    // Stalled branch to 0x200; later branch inputs during the wait are ignored.
    step(0, 0, 0, 0, 64'h0);
    step(1, 1, 1, 1, 64'h200);
    chk("stall_hold_0", pc_out, 64'h0);
    step(1, 1, 1, 1, 64'h999);
    chk("stall_hold_1", pc_out, 64'h0);
    step(1, 1, 1, 1, 64'hABC);
    chk("stall_noflush", {62'h0, if_id_flush, id_ex_flush}, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    chk("pend_pc", pc_out, 64'h200);
    chk("pend_flush", {62'h0, if_id_flush, id_ex_flush}, 64'h3);
    chk("pend_counts", {branch_count, taken_count}, {32'h1, 32'h1});
    step(1, 0, 0, 0, 64'h0);
    chk("pend_after_pc", pc_out, 64'h204);

    // Not taken, then a misaligned taken target.
    step(1, 0, 1, 0, 64'h400);
    chk("nt_pc", pc_out, 64'h208);
    chk("nt_bc", {32'h0, branch_count}, 64'h2);
    step(1, 0, 1, 1, 64'h302);
    chk("mis_pc", pc_out, 64'h300);
    chk("mis_err", {63'h0, misalign_err}, 64'h1);
    step(1, 0, 0, 0, 64'h0);
    chk("mis_clear", {63'h0, misalign_err}, 64'h0);
    chk("mis_after_pc", pc_out, 64'h304);

    // Reset while a redirect is waiting: the redirect is discarded.
    step(1, 1, 1, 1, 64'h700);
    step(0, 1, 0, 0, 64'h0);
    chk("rst_pend_pc", pc_out, 64'h0);
    chk("rst_pend_counts", {branch_count, taken_count}, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    chk("rst_pend_noflush", {62'h0, if_id_flush, id_ex_flush}, 64'h0);
    chk("rst_pend_pc4", pc_out, 64'h4);
    step(1, 0, 0, 0, 64'h0);
    chk("rst_pend_noflush2", {62'h0, if_id_flush, id_ex_flush}, 64'h0);

    // Counter saturation and PC wrap.
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    m_bc = 32'hFFFF_FFFE; m_tc = 32'hFFFF_FFFE;
    step(1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sat_pc_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sat_counts", {branch_count, taken_count}, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 1, 0, 0, 64'h0);
    chk("wrap_hold", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 1, 0, 64'h0);
    chk("wrap_zero", pc_out, 64'h0);
    step(1, 0, 1, 1, 64'h40);
    chk("sat_hold", {branch_count, taken_count}, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 0, 0, 0, 64'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [63:0] bt;
      case ($urandom_range(0, 3))
        0: bt = {32'h0, $urandom} & ~64'h3;
        1: bt = {$urandom, $urandom};
        2: bt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: bt = 64'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, bt);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_branch_ctrl.md
PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 64'd4, the sequential PC increment.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port stall  input  1  hazard-unit stall; 1 means hold the PC.
REQ-006 SHALL have port branch_valid  input  1  EX stage holds a valid conditional branch.
REQ-007 SHALL have port addermuxselect  input  1  branch-taken decision from the branch comparator (beq/blt/bgt).
REQ-008 SHALL have port branch_target  input  64  branch target address computed in EX.
REQ-009 SHALL have port pc_out  output  64  registered fetch PC.
REQ-010 SHALL have port if_id_flush  output  1  registered; clears the IF/ID register.
REQ-011 SHALL have port id_ex_flush  output  1  registered; clears the ID/EX register.
REQ-012 SHALL have port misalign_err  output  1  registered one-cycle pulse on a misaligned taken target.
REQ-013 SHALL have port branch_count  output  32  number of accepted branch evaluations.
REQ-014 SHALL have port taken_count  output  32  number of taken branches.

Function
REQ-015 SHALL implement states RUN, PENDING, FLUSH; redirect_req = branch_valid & addermuxselect.
REQ-016 In RUN with stall=0 and redirect_req=0, pc_out SHALL become pc_out+PC_STEP, modulo 2^64; FFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-017 In RUN with stall=1 and redirect_req=0, pc_out SHALL hold.
REQ-018 In RUN with redirect_req=1 and stall=0, pc_out SHALL load {branch_target[63:2],2'b00} at the next edge, and the state SHALL go to FLUSH.
REQ-019 In RUN with redirect_req=1 and stall=1, the block SHALL latch branch_target into a pending register, hold pc_out, and go to PENDING.
REQ-020 In PENDING, the pending target SHALL be loaded into pc_out on the first edge with stall=0, and the state SHALL go to FLUSH; while stall=1, pc_out and the pending target SHALL hold.
REQ-021 In PENDING, branch_valid and addermuxselect SHALL be ignored.
REQ-022 if_id_flush and id_ex_flush SHALL both be 1 for exactly the one cycle spent in FLUSH, and 0 otherwise.
REQ-023 In FLUSH, branch_valid SHALL be ignored; pc_out SHALL increment if stall=0 or hold if stall=1; the next state SHALL always be RUN.
REQ-024 misalign_err SHALL pulse for one cycle, coincident with FLUSH, when the accepted target has bits [1:0] != 0.
REQ-025 branch_count SHALL increment when branch_valid=1 in RUN (stall ignored); it SHALL saturate at 32'hFFFF_FFFF.
REQ-026 taken_count SHALL increment once per redirect, at the entry to PENDING or direct entry to FLUSH, and SHALL saturate at 32'hFFFF_FFFF.
REQ-027 At most one redirect SHALL be generated per branch; a second redirect_req arriving before the block returns to RUN SHALL be dropped.

Reset
REQ-028 When reset=0 at a clock edge, the block SHALL set pc_out=RESET_PC, state=RUN, both flush outputs=0, misalign_err=0, both counters=0, and pending target=0, regardless of any other input.
REQ-029 A reset that arrives while in PENDING or FLUSH SHALL discard the pending redirect; no flush pulse SHALL follow the reset.
REQ-030 The block SHALL have no initial blocks; reset is the only initialisation.

Verification
REQ-031 Sequential fetch: reset released, stall=0, no branches for 3 cycles -> pc_out = 0, 4, 8, 12.
REQ-032 Taken branch: at pc_out=0x10, branch_valid=1, addermuxselect=1, target=0x100 -> next cycle pc_out=0x100 and both flushes=1 for one cycle; the cycle after, pc_out=0x104 and flushes=0; taken_count=1.
REQ-033 Stalled branch: taken branch to 0x200 while stall=1 for 3 cycles -> pc_out held and no flush during the stall; first cycle after stall=0, pc_out=0x200 and flush pulses once; taken_count=1, branch_count=1.
REQ-034 Not taken, then misaligned: branch_valid=1, addermuxselect=0 -> pc increments and branch_count increments; then taken branch to 0x302 -> pc_out=0x300 and misalign_err=1 for one cycle.
REQ-035 Reset mid-PENDING: reset=0 while in PENDING -> pc_out=RESET_PC, counters=0, and no flush after reset is released.
REQ-036 Saturation and wrap: counters preloaded near the limit via a force -> they stay at 32'hFFFF_FFFF; pc_out=64'hFFFF_FFFF_FFFF_FFFC with stall=0 -> next pc_out=0.
